div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX launches an operation with `start_i`, stalls the pipeline while `ready_o` is low, then writes `result_o` to HI/LO through its existing HI/LO write path (`whilo_o`/`hi_o`/`lo_o`). The divider is a radix-2 restoring design with one quotient bit per cycle, a divide-by-zero short path and annul support for flushes.

## Interface
Parameters: none. Widths come from `RegBus` (32) and `DoubleRegBus` (64) in defines.v.
- `clk`  in  1  system clock; every flop updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  32  dividend; sampled only on the start edge.
- `opdata2_i`  in  32  divisor; sampled only on the start edge.
- `start_i`  in  1  request; EX holds it high until it has consumed the result.
- `annul_i`  in  1  abort the current operation (branch-delay or exception flush).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; EX writes [63:32] to HI and [31:0] to LO.
- `ready_o`  out  1  result valid.

## Operation
- State register `state` has four states: DivFree, DivByZero, DivOn, DivEnd.
- Internal registers:
  - `dividend` is 65 bits.
  - `divisor` is 32 bits.
  - `cnt` is 6 bits.
  - Sign flags `s1` and `s2` are captured at start.
- **Reset** (rst=0, at any time, including mid-operation): state=DivFree, cnt=0, result_o=0, ready_o=0, all internal registers cleared.
- **DivFree**
  - If start_i=1 and annul_i=0 and opdata2_i==0: go to DivByZero.
  - If start_i=1 and annul_i=0 and opdata2_i!=0: go to DivOn and load the operands:
    - cnt=0.
    - Load magnitudes: when signed_div_i=1, an operand with bit31 set is replaced by its two's-complement negation. An operand of 0x80000000 stays 0x80000000, treated as unsigned 2^31.
    - dividend = {32'b0, \|op1\|, 1'b0}.
    - divisor = \|op2\|.
    - s1 = signed_div_i & opdata1_i[31]; s2 = signed_div_i & opdata2_i[31].
  - Otherwise: result_o=0, ready_o=0, stay in DivFree.
- **DivByZero**: unconditionally go to DivEnd with dividend=0, so the result is 0. No exception is raised; MIPS leaves the result UNPREDICTABLE and the team has fixed it at 0.
- **DivOn**
  - annul_i=1: go to DivFree; ready_o stays 0.
  - Otherwise, while cnt<32, perform one step:
    - diff = {1'b0, dividend[63:32]} − {1'b0, divisor}.
    - If diff is negative: dividend = dividend<<1.
    - Else: dividend = {diff[31:0], dividend[31:0], 1'b1}.
    - cnt = cnt+1.
  - When cnt==32:
    - q = dividend[31:0], negated if s1^s2.
    - r = dividend[64:33], negated if s1.
    - result_o = {r, q}, ready_o=1, go to DivEnd, cnt=0.
- **DivEnd**
  - result_o and ready_o hold while start_i=1.
  - When start_i=0: result_o=0, ready_o=0, go to DivFree.
- Arithmetic: all steps are unsigned 33-bit. The sign of the remainder follows the dividend, and the quotient truncates toward zero.
- Simultaneous events:
  - rst overrides everything.
  - annul_i in DivFree blocks the start.
  - annul_i in DivByZero and DivEnd is ignored; EX drops start_i instead.

## Timing
- Start edge = T0, the first rising edge with start_i=1 in DivFree.
- Normal division:
  - Iterations occur at edges T1..T32.
  - At T33: result_o is loaded and ready_o=1.
  - ready_o is visible in the cycle after T33, giving 34 cycles of stall in EX.
- Divide by zero: DivByZero after T0, DivEnd at T1; ready_o visible after T1.
- The first edge with start_i=0 in DivEnd clears ready_o and result_o at that edge.
- A new start may be sampled on the edge after the return to DivFree, so back-to-back operations have one idle cycle.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Structure
- These constants are added to defines.v:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady 1'b1, DivResultNotReady 1'b0.
  - DivStart 1'b1, DivStop 1'b0.
  - EXE_DIV_OP and EXE_DIVU_OP, if not already present.
- The block is a single module; no sub-module is natural. The subtractor and sign fix are small enough to stay inline.
- EX changes that belong to EX's own spec:
  - stallreq_for_div = start_i & ~ready_o.
  - On ready_o, the DIV/DIVU HI/LO write uses result_o.

## Test plan
- Unsigned 100/7 (signed_div_i=0), start held → ready_o rises exactly 34 cycles after T0 with result_o = 0x00000002_0000000E; drop start → ready_o=0 and result_o=0 on the next edge.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD (r=−1, q=−3). The same operands as DIVU → q=0x7FFFFFFC, r=1.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. Unsigned 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- Divisor 0, start at T0 → state passes DivByZero then DivEnd; ready_o visible after T1 with result_o=0.
- annul_i pulsed 10 cycles into DivOn → state=DivFree on the next edge and ready_o never rises. A new start of 9/3 then yields q=3, r=0 with full 34-cycle latency.
- rst driven low asynchronously mid-DivOn, between edges → ready_o=0, result_o=0 and state=DivFree immediately. After release, a start of 50/5 completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM state encoding and helpers for the multi-cycle divider
package div_pkg;
  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  // magnitude of an operand; 0x80000000 stays put and is read as unsigned 2^31
  function automatic logic [RegBus-1:0] mag(input logic [RegBus-1:0] v, input logic sgn);
    return (sgn && v[RegBus-1]) ? ~v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/div.sv
// div: radix-2 restoring 32-bit divider for DIV/DIVU with divide-by-zero short path and annul
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);
  div_state_e              r_state, w_state;
  logic [64:0]             r_dividend, w_dividend;
  logic [RegBus-1:0]       r_divisor, w_divisor;
  logic [5:0]              r_cnt, w_cnt;
  logic                    r_s1, r_s2, w_s1, w_s2;
  logic [DoubleRegBus-1:0] w_result;
  logic                    w_ready;
  logic [RegBus:0]         w_diff;
  logic [RegBus-1:0]       w_q, w_r;
  assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};
  assign w_q    = (r_s1 ^ r_s2) ? -r_dividend[31:0] : r_dividend[31:0];
  assign w_r    = r_s1 ? -r_dividend[64:33] : r_dividend[64:33];
  // next-state and datapath updates for every state
  always_comb begin
    w_state    = r_state;
    w_dividend = r_dividend;
    w_divisor  = r_divisor;
    w_cnt      = r_cnt;
    w_s1       = r_s1;
    w_s2       = r_s2;
    w_result   = result_o;
    w_ready    = ready_o;
    case (r_state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state = DIV_BY_ZERO;
          end else begin
            w_state    = DIV_ON;
            w_cnt      = '0;
            w_dividend = {32'b0, mag(opdata1_i, signed_div_i), 1'b0};
            w_divisor  = mag(opdata2_i, signed_div_i);
            w_s1       = signed_div_i & opdata1_i[31];
            w_s2       = signed_div_i & opdata2_i[31];
          end
        end else begin
          w_result = '0;
          w_ready  = DIV_RESULT_NOT_READY;
        end
      end
      DIV_BY_ZERO: begin
        w_state    = DIV_END;
        w_dividend = '0;
        w_result   = '0;
        w_ready    = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state = DIV_FREE;
        end else if (r_cnt != 6'd32) begin
          w_dividend = w_diff[RegBus] ? {r_dividend[63:0], 1'b0}
                                      : {w_diff[31:0], r_dividend[31:0], 1'b1};
          w_cnt      = r_cnt + 6'd1;
        end else begin
          w_result = {w_r, w_q};
          w_ready  = DIV_RESULT_READY;
          w_state  = DIV_END;
          w_cnt    = '0;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_result = '0;
          w_ready  = DIV_RESULT_NOT_READY;
          w_state  = DIV_FREE;
        end
      end
      default: w_state = DIV_FREE;
    endcase
  end
  // state and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DIV_FREE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      r_state    <= w_state;
      r_dividend <= w_dividend;
      r_divisor  <= w_divisor;
      r_cnt      <= w_cnt;
      r_s1       <= w_s1;
      r_s2       <= w_s2;
      result_o   <= w_result;
      ready_o    <= w_ready;
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: directed and randomized checks of div against an arithmetic reference model
module tb_div;
  import div_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  int vec = 0;
  int miss = 0;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {remainder, quotient} from plain arithmetic; divide by zero yields 0
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = int'(a);
    sb = int'(b);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp);
    int n;
    int lat;
    logic got;
    lat = (b == 0) ? 2 : 34;
    @(negedge clk);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = sgn;
    start_i = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      got = ready_o;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_result"}, result_o, exp);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    @(negedge clk);
    check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic sgn;
    bit seen;
    repeat (2) @(negedge clk);
    check("reset_out", {result_o[62:0], ready_o}, 64'd0);
    rst = 1'b1;
    run_op("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
    run_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF);
    run_op("div0", 32'd1234, 32'd0, 1'b1, 64'd0);
    // annul ten cycles into the iteration
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_state", 64'(dut.r_state), 64'(DIV_FREE));
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready_o;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_op("after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003);
    // asynchronous reset between edges mid-iteration
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", {result_o[62:0], ready_o}, 64'd0);
    check("async_rst_state", 64'(dut.r_state), 64'(DIV_FREE));
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 32'd50, 32'd5, 1'b0, 64'h00000000_0000000A);
    // randomized operands, with occasional zero and small divisors
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (i % 6 == 5) b = 32'd0;
      else if (i % 4 == 1) b = 32'($urandom_range(1, 16)) ^ (sgn ? 32'hFFFF_FFF0 : 32'd0);
      if (i % 8 == 3) a = 32'h8000_0000;
      run_op("rand", a, b, sgn, model(a, b, sgn));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
